// File: rtl/multiplier_iter_radix.sv
// Iterative W x W multiplier with a runtime signed/unsigned mode. Each CALC
// cycle retires N bits of b. Valid/ready handshakes on the operand and result sides.
module multiplier_iter_radix #(
   parameter int W = 32,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           signed_mode,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] product
);

   localparam int ITER = W / N;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   generate
      if ((N < 1) || (N > W) || (W % N != 0)) begin : g_bad_radix
         $error("multiplier_iter_radix: W must be a nonzero multiple of N");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_last;

   logic [W-1:0]     r_a_mag;
   logic [W-1:0]     r_b_mag;
   logic             r_neg;
   logic [2*W-1:0]   r_acc;
   logic [CW-1:0]    r_cnt;
   logic [2*W-1:0]   r_product;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [W-1:0]     w_a_mag;
   logic [W-1:0]     w_b_mag;
   logic [W+N-1:0]   w_pp;
   logic [31:0]      w_shamt;
   logic [2*W-1:0]   w_pp_shift;
   logic [2*W-1:0]   w_acc_sum;
   logic [2*W-1:0]   w_acc_neg;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == LAST) begin
               w_last       = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Magnitudes are W-bit unsigned, so -2^(W-1) maps exactly onto 2^(W-1).
   always_comb begin
      w_a_neg    = signed_mode & a[W-1];
      w_b_neg    = signed_mode & b[W-1];
      w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
      w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
      w_pp       = (W+N)'(r_a_mag) * (W+N)'(r_b_mag[N-1:0]);
      w_shamt    = 32'(r_cnt) * 32'(N);
      w_pp_shift = (2*W)'(w_pp) << w_shamt;
      w_acc_sum  = r_acc + w_pp_shift;
      w_acc_neg  = ~w_acc_sum + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a_mag   <= '0;
         r_b_mag   <= '0;
         r_neg     <= 1'b0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_a_mag <= w_a_mag;
         r_b_mag <= w_b_mag;
         r_neg   <= signed_mode & (a[W-1] ^ b[W-1]);
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
         r_acc   <= w_acc_sum;
         r_b_mag <= r_b_mag >> N;
         r_cnt   <= r_cnt + 1'b1;
         // Negating a zero sum yields zero, so -0 never escapes as nonzero.
         if (w_last) r_product <= r_neg ? w_acc_neg : w_acc_sum;
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_multiplier_iter_radix.sv
// Directed-vector and random bench for multiplier_iter_radix: W32/N4, W16/N2, W32/N8 instances.
module tb_multiplier_iter_radix;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  iv, md, ordy;
   logic [2:0]  irdy, ov;
   logic [31:0] a_s [3];
   logic [31:0] b_s [3];
   logic [63:0] p0, p2;
   logic [31:0] p1;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          iter_k [3] = '{8, 8, 4};

   always #5 clk = ~clk;

   multiplier_iter_radix #(.W(32), .N(4)) u_w32n4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
      .signed_mode(md[0]), .a(a_s[0]), .b(b_s[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .product(p0));

   multiplier_iter_radix #(.W(16), .N(2)) u_w16n2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
      .signed_mode(md[1]), .a(a_s[1][15:0]), .b(b_s[1][15:0]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .product(p1));

   multiplier_iter_radix #(.W(32), .N(8)) u_w32n8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
      .signed_mode(md[2]), .a(a_s[2]), .b(b_s[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .product(p2));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        mode;
      logic [63:0] exp;
   } vec_t;

   function automatic logic [63:0] prod_of(input int k);
      if (k == 0)      return p0;
      else if (k == 1) return {32'h0, p1};
      else             return p2;
   endfunction

   function automatic logic [63:0] ref_mul(input int k, input logic [31:0] x,
                                           input logic [31:0] y, input logic m);
      logic [15:0] x16, y16;
      longint      sp;
      logic [63:0] up;
      x16 = x[15:0];
      y16 = y[15:0];
      if (k == 1) begin
         sp = longint'($signed(x16)) * longint'($signed(y16));
         up = {48'h0, x16} * {48'h0, y16};
         return m ? {32'h0, sp[31:0]} : {32'h0, up[31:0]};
      end
      sp = longint'($signed(x)) * longint'($signed(y));
      up = {32'h0, x} * {32'h0, y};
      return m ? sp : up;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_op(input int k, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tm, input logic [63:0] exp, input string tag);
      int cyc;
      cyc = 0;
      while (!irdy[k] && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      a_s[k] = ta; b_s[k] = tb_v; md[k] = tm; iv[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0; a_s[k] = ~ta; b_s[k] = $urandom; md[k] = ~tm;
      cyc = 0;
      while (!ov[k] && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(iter_k[k]));
      check({tag, " product"}, prod_of(k), exp);
      ordy[k] = 1'b1;
      @(posedge clk); #1;
      ordy[k] = 1'b0;
      check({tag, " release"}, {62'h0, ov[k], irdy[k]}, 64'h1);
      $display("[TB] inst%0d a=%h b=%h mode=%0d -> %h", k, ta, tb_v, tm, prod_of(k));
   endtask

   vec_t vecs [13];

   initial begin
      int cyc, seen;
      logic [31:0] x, y;
      logic m;

      vecs[0]  = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
      vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
      vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
      vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
      vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000};
      vecs[5]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0};
      vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 64'h0};
      vecs[7]  = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
      vecs[8]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
      vecs[9]  = '{32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 64'h0000_0002_FFFF_FFFD};
      vecs[10] = '{32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};
      vecs[11] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
      vecs[12] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};

      rst_n = 1'b0; iv = '0; md = '0; ordy = '0;
      for (int k = 0; k < 3; k++) begin
         a_s[k] = '0; b_s[k] = '0;
      end

      // Reset held for three edges while the inputs toggle.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         iv = ~iv; ordy = ~ordy; md = ~md;
         a_s[0] = $urandom; b_s[0] = $urandom;
      end
      @(posedge clk); #1;
      check("reset in_ready", {63'h0, irdy[0]}, 64'h1);
      check("reset out_valid", {63'h0, ov[0]}, 64'h0);
      check("reset product", p0, 64'h0);
      iv = '0; ordy = '0; md = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++)
         do_op(0, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));

      // Backpressure: result held while out_ready stays low; new operands ignored.
      do_op(0, 32'd3, 32'd5, 1'b0, 64'd15, "bp_pre");
      a_s[0] = 32'd3; b_s[0] = 32'd5; md[0] = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b1; a_s[0] = 32'd2; b_s[0] = 32'd9;
      cyc = 0;
      while (!ov[0] && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("bp latency", 64'(cyc), 64'd8);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d product", i), p0, 64'd15);
         check($sformatf("bp%0d flags", i), {62'h0, ov[0], irdy[0]}, 64'h2);
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      check("bp release flags", {62'h0, ov[0], irdy[0]}, 64'h1);
      check("bp product hold", p0, 64'd15);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      check("bp next accept", {63'h0, irdy[0]}, 64'h0);
      cyc = 0;
      while (!ov[0] && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("bp second product", p0, 64'd18);
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      $display("[TB] backpressure sequence done, product=%h", p0);

      // Abort: reset during the fourth CALC cycle.
      a_s[0] = 32'd7; b_s[0] = 32'd7; md[0] = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort in_ready", {63'h0, irdy[0]}, 64'h1);
      check("abort product", p0, 64'h0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (ov[0]) seen++;
      end
      check("abort no out_valid", 64'(seen), 64'h0);
      $display("[TB] abort sequence done, out_valid cycles=%0d", seen);
      do_op(0, 32'd7, 32'd7, 1'b0, 64'd49, "post_abort");

      // Random operands against the reference model on the other radices.
      for (int k = 1; k < 3; k++) begin
         for (int i = 0; i < 500; i++) begin
            x = $urandom; y = $urandom; m = 1'($urandom_range(0, 1));
            if (i % 8 == 0) x = 32'h8000_0000;
            if (i % 16 == 0) y = 32'h8000_0000;
            if (i % 32 == 5) y = 32'h0;
            if (k == 1) begin
               x = {16'h0, x[31:16] | x[15:0]};
               y = {16'h0, y[15:0]};
               if (i % 8 == 0) x = 32'h0000_8000;
               if (i % 16 == 0) y = 32'h0000_8000;
            end
            do_op(k, x, y, m, ref_mul(k, x, y, m), $sformatf("rnd%0d_%0d", k, i));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
